decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised RV32/RV64 instruction decode stage that sits between fetch and execute. It decodes one instruction per cycle into immediate, register indices, ALU code, branch type and control word. Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides. Over the existing combinational decode helpers it adds XLEN-wide immediates, illegal-instruction detection, back-pressure buffering and flush.

## Interface
- XLEN, 32, datapath/immediate width; legal values 32 or 64
- DEPTH, 2, decoded-entry FIFO depth; power of two, ≥ 2
- clock  in  1  rising-edge clock
- nReset  in  1  asynchronous active-low reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts; registered, equals (count != DEPTH)
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- flush  in  1  synchronous: discard all buffered entries
- out_valid  out  1  head entry present
- out_ready  in  1  execute consumes head
- out_pc  out  XLEN  PC of head entry
- out_imm  out  XLEN  sign-extended immediate
- out_rd, out_rs1, out_rs2  out  5 each  register indices (instr[11:7], [19:15], [24:20])
- out_funct3  out  3  instr[14:12]
- out_alu_code  out  4  ALU code (ADD 0000 … NOP 1111)
- out_branch_type  out  2  NON 0, JAL 1, JALR 2, CONDITIONAL 3
- out_ctrl  out  10  control word
- out_illegal  out  1  instruction illegal
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Decode is combinational on in_instr. A decoded record is written to the FIFO when in_valid && in_ready.
- Opcode is instr[6:2]. instr[1:0] != 2'b11 → illegal.
- Immediate formats: I for OPIMM/LOAD/JALR; S for STORE; B for BRANCH; U for LUI/AUIPC; J for JAL; 0 for OP. All formats sign-extend from instr[31] to XLEN; U sign-extends from bit 31 when XLEN=64.
- out_ctrl by opcode: LUI 0x040, AUIPC 0x05E, OPIMM 0x04E, OP 0x046, LOAD 0x06F, STORE 0x08E, JAL 0x142, JALR 0x04A, BRANCH 0x000.
- out_alu_code by opcode:
  - OP: {instr[30], funct3}.
  - OPIMM: {instr[30], funct3} when funct3=101, else {0, funct3}.
  - BRANCH: SUB (1000).
  - All other legal opcodes: ADD.
- out_branch_type: JAL → 1, JALR → 2, BRANCH → 3, otherwise 0.
- Illegal conditions:
  - Opcode outside the nine listed.
  - OP with funct7 ∉ {0000000, 0100000}, or funct7=0100000 with funct3 ∉ {000, 101}.
  - OPIMM shifts:
    - SLLI: instr[31:25] (XLEN=32) or instr[31:26] (XLEN=64) must be 0.
    - SRLI/SRAI: the same field must be 0, or must equal 0100000 (XLEN=32) / 010000 (XLEN=64).
    - XLEN=32 with instr[25]=1 on a shift → illegal.
  - JALR with funct3 != 000; BRANCH with funct3 ∈ {010, 011}.
  - LOAD funct3 ∉ {000,001,010,100,101}; XLEN=64 additionally allows 011 and 110.
  - STORE funct3 ∉ {000,001,010}; XLEN=64 additionally allows 011.
- Illegal instructions are still enqueued with out_illegal=1, out_ctrl=0, out_alu_code=NOP, out_branch_type=0, out_imm=0.
- FIFO: circular head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. Pop on out_valid && out_ready. out_* present the head entry; all out_* data fields read 0 when out_valid=0.

## Timing
- Reset (async assert, sync release): count=0, pointers=0, out_valid=0, in_ready=1, all out_* data fields 0.
- Latency: an instruction accepted at edge N appears on out_* after edge N when the FIFO was empty. Latency is 1 cycle; there is no combinational in→out path.
- Simultaneous push and pop: count unchanged. Push and pop in the same cycle is allowed only while count < DEPTH (in_ready registered), so a full FIFO takes one cycle after a pop to reopen.
- Full (count=DEPTH): in_ready=0; in_valid is ignored.
- Empty: out_valid=0; out_ready is ignored.
- Flush beats push and pop in the same cycle: next state count=0, pointers=0, out_valid=0, in_ready=1; any in_valid that cycle is dropped.
- nReset asserted mid-operation clears immediately regardless of clock; buffered entries are lost.
- out_* must remain stable while out_valid && !out_ready.

## Test plan
- Reset: nReset=0 with in_valid=1 → out_valid=0, in_ready=1, count=0; after release, count stays 0 until first accepted push.
- Push 0xFFF00093 (addi x1,x0,-1), pc 0x100, out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, rd=1, rs1=0, alu=0000, ctrl=0x04E, branch_type=0, illegal=0; count returns to 0 after pop.
- Push 0xFE208EE3 (beq x1,x2,-4) → out_imm=0xFFFFFFFC, rs1=1, rs2=2, alu=1000, branch_type=3, ctrl=0x000.
- DEPTH=2, out_ready=0, push A, B, C back-to-back → count=2, in_ready=0 after B, C held. Then out_ready=1 for one cycle → A popped, in_ready=1 next cycle, C accepted, output order A, B, C.
- Two entries buffered, assert flush with in_valid=1 → next cycle count=0, out_valid=0, in_ready=1; flushed data never appears.
- Push 0x00000000 → out_illegal=1, alu=1111, ctrl=0; XLEN=64 build, push 0x800000B7 (lui x1,0x80000) → out_imm=0xFFFFFFFF80000000, ctrl=0x040.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-to-execute decode stage bus: instruction offer side, decoded-record side, flush and occupancy.
// The decode stage takes the slave modport; the fetch/execute environment takes the master modport.
interface decode_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_imm;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [2:0]        out_funct3;
    logic [3:0]        out_alu_code;
    logic [1:0]        out_branch_type;
    logic [9:0]        out_ctrl;
    logic              out_illegal;
    logic [CW-1:0]     count;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2,
               out_funct3, out_alu_code, out_branch_type, out_ctrl, out_illegal, count
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2,
               out_funct3, out_alu_code, out_branch_type, out_ctrl, out_illegal, count
    );
endinterface

// File: rtl/decode_stage.sv
// RV32/RV64 decode stage: combinational decode of the offered instruction into a record,
// buffered in a DEPTH-entry FIFO whose head is held in a register that drives the outputs.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic           clock,
    input  logic           nReset,
    decode_stage_if.slave  bus
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam bit          RV64 = (XLEN == 64);

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [3:0]      alu_code;
        logic [1:0]      branch_type;
        logic [9:0]      ctrl;
        logic            illegal;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          dec;
    entry_t          head_q, head_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            push, pop;

    logic [31:0]     instr;
    logic [4:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [6:0]      sh_hi;
    logic [6:0]      sra_pat;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu;
    logic [1:0]      br;
    logic [9:0]      ctrl;
    logic            ill;

    assign instr   = bus.in_instr;
    assign opc     = instr[6:2];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    // Shift-amount high field differs by XLEN: shamt[5] is part of it only on RV32.
    assign sh_hi   = RV64 ? {1'b0, instr[31:26]} : instr[31:25];
    assign sra_pat = RV64 ? 7'b0010000 : 7'b0100000;

    // Instruction decode
    always_comb begin
        imm  = '0;
        alu  = 4'b0000;
        br   = 2'd0;
        ctrl = 10'h000;
        ill  = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                imm  = XLEN'($signed({instr[31:12], 12'b0}));
                ctrl = (opc == OPC_LUI) ? 10'h040 : 10'h05E;
            end
            OPC_OPIMM: begin
                imm  = XLEN'($signed(instr[31:20]));
                ctrl = 10'h04E;
                alu  = (f3 == 3'b101) ? {instr[30], f3} : {1'b0, f3};
                if (f3 == 3'b001) ill = (sh_hi != 7'd0);
                if (f3 == 3'b101) ill = !((sh_hi == 7'd0) || (sh_hi == sra_pat));
            end
            OPC_OP: begin
                ctrl = 10'h046;
                alu  = {instr[30], f3};
                if (f7 == 7'b0100000)      ill = !((f3 == 3'b000) || (f3 == 3'b101));
                else if (f7 != 7'b0000000) ill = 1'b1;
            end
            OPC_LOAD: begin
                imm  = XLEN'($signed(instr[31:20]));
                ctrl = 10'h06F;
                case (f3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ill = 1'b0;
                    3'b011, 3'b110:                         ill = !RV64;
                    default:                                ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                imm  = XLEN'($signed({instr[31:25], instr[11:7]}));
                ctrl = 10'h08E;
                case (f3)
                    3'b000, 3'b001, 3'b010: ill = 1'b0;
                    3'b011:                 ill = !RV64;
                    default:                ill = 1'b1;
                endcase
            end
            OPC_JAL: begin
                imm  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
                ctrl = 10'h142;
                br   = 2'd1;
            end
            OPC_JALR: begin
                imm  = XLEN'($signed(instr[31:20]));
                ctrl = 10'h04A;
                br   = 2'd2;
                ill  = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
                alu  = 4'b1000;
                br   = 2'd3;
                ill  = (f3 == 3'b010) || (f3 == 3'b011);
            end
            default: ill = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) ill = 1'b1;
        if (ill) begin
            imm  = '0;
            alu  = 4'b1111;
            br   = 2'd0;
            ctrl = 10'h000;
        end
    end

    always_comb begin
        dec             = '0;
        dec.pc          = bus.in_pc;
        dec.imm         = imm;
        dec.rd          = instr[11:7];
        dec.rs1         = instr[19:15];
        dec.rs2         = instr[24:20];
        dec.funct3      = f3;
        dec.alu_code    = alu;
        dec.branch_type = br;
        dec.ctrl        = ctrl;
        dec.illegal     = ill;
    end

    assign push = bus.in_valid && in_ready_q;
    assign pop  = out_valid_q && bus.out_ready;

    // FIFO next state; the next head is the freshly decoded record when it lands at the new read pointer
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        head_d      = '0;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            count_d  = count_q + CW'(push) - CW'(pop);
            if (count_d != '0) begin
                if (push && (wr_ptr_q == rd_ptr_d)) head_d = dec;
                else                                head_d = mem[rd_ptr_d];
            end
        end
        in_ready_d  = (count_d != CW'(DEPTH));
        out_valid_d = (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (push && !bus.flush) mem[wr_ptr_q] <= dec;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.count           = count_q;
    assign bus.out_pc          = head_q.pc;
    assign bus.out_imm         = head_q.imm;
    assign bus.out_rd          = head_q.rd;
    assign bus.out_rs1         = head_q.rs1;
    assign bus.out_rs2         = head_q.rs2;
    assign bus.out_funct3      = head_q.funct3;
    assign bus.out_alu_code    = head_q.alu_code;
    assign bus.out_branch_type = head_q.branch_type;
    assign bus.out_ctrl        = head_q.ctrl;
    assign bus.out_illegal     = head_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32 and an RV64 build share one stimulus stream and
// are each checked against a spec-level reference decoder and an expected-record queue.
module tb_decode_stage;
    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [1:0]  br;
        logic [9:0]  ctrl;
        logic        ill;
    } exp_t;

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    bit          mon_en = 1'b0;

    int checks = 0;
    int errors = 0;
    exp_t q32[$];
    exp_t q64[$];

    decode_stage_if #(.XLEN(32), .DEPTH(DEPTH)) if32 ();
    decode_stage_if #(.XLEN(64), .DEPTH(DEPTH)) if64 ();

    decode_stage #(.XLEN(32), .DEPTH(DEPTH)) u_dut32 (.clock(clock), .nReset(nReset), .bus(if32));
    decode_stage #(.XLEN(64), .DEPTH(DEPTH)) u_dut64 (.clock(clock), .nReset(nReset), .bus(if64));

    assign if32.in_valid  = in_valid;
    assign if32.in_instr  = in_instr;
    assign if32.in_pc     = in_pc[31:0];
    assign if32.flush     = flush;
    assign if32.out_ready = out_ready;
    assign if64.in_valid  = in_valid;
    assign if64.in_instr  = in_instr;
    assign if64.in_pc     = in_pc;
    assign if64.flush     = flush;
    assign if64.out_ready = out_ready;

    always #5 clock = ~clock;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decoder built from the opcode tables, immediates by arithmetic on the signed word
    function automatic exp_t ref_decode(logic [31:0] i, logic [63:0] pc, bit is64);
        exp_t e;
        int   s;
        int   immw;
        logic [2:0] f3;
        bit ill;
        s = i;
        f3 = i[14:12];
        immw = 0;
        ill = 0;
        e.pc = is64 ? pc : {32'b0, pc[31:0]};
        e.rd = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.f3 = f3;
        e.alu = 4'h0;
        e.br = 2'd0;
        e.ctrl = 10'h000;
        case (i[6:2])
            5'b01101: begin e.ctrl = 10'h040; immw = s & 32'hFFFF_F000; end
            5'b00101: begin e.ctrl = 10'h05E; immw = s & 32'hFFFF_F000; end
            5'b00100: begin
                e.ctrl = 10'h04E; immw = s >>> 20;
                e.alu = (f3 == 3'd5) ? {i[30], f3} : {1'b0, f3};
                if (f3 == 3'd1) ill = is64 ? (i[31:26] != 6'd0) : (i[31:25] != 7'd0);
                if (f3 == 3'd5) ill = is64 ? !(i[31:26] inside {6'h00, 6'h10})
                                           : !(i[31:25] inside {7'h00, 7'h20});
            end
            5'b01100: begin
                e.ctrl = 10'h046; immw = 0; e.alu = {i[30], f3};
                ill = !(i[31:25] inside {7'h00, 7'h20}) || (i[31:25] == 7'h20 && !(f3 inside {3'd0, 3'd5}));
            end
            5'b00000: begin
                e.ctrl = 10'h06F; immw = s >>> 20;
                ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} || (is64 && f3 inside {3'd3, 3'd6}));
            end
            5'b01000: begin
                e.ctrl = 10'h08E; immw = ((s >>> 25) <<< 5) | int'(i[11:7]);
                ill = !(f3 inside {3'd0, 3'd1, 3'd2} || (is64 && f3 == 3'd3));
            end
            5'b11011: begin
                e.ctrl = 10'h142; e.br = 2'd1;
                immw = ((s >>> 31) <<< 20) | int'({i[19:12], i[20], i[30:21], 1'b0});
            end
            5'b11001: begin e.ctrl = 10'h04A; e.br = 2'd2; immw = s >>> 20; ill = (f3 != 3'd0); end
            5'b11000: begin
                e.alu = 4'b1000; e.br = 2'd3; ill = f3 inside {3'd2, 3'd3};
                immw = ((s >>> 31) <<< 12) | int'({i[7], i[30:25], i[11:8], 1'b0});
            end
            default: ill = 1;
        endcase
        if (i[1:0] != 2'b11) ill = 1;
        e.ill = ill;
        e.imm = is64 ? 64'(longint'(immw)) : {32'b0, immw};
        if (ill) begin
            e.imm = '0; e.ctrl = 10'h000; e.alu = 4'hF; e.br = 2'd0;
        end
        return e;
    endfunction

    // One cycle of stimulus, called just after a rising edge; expectations land after the next edge
    task automatic drive(bit v, logic [31:0] ins, logic [63:0] pc, bit fl, bit rdy);
        bit acc;
        exp_t e32, e64;
        in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = rdy;
        acc = v && !fl && (q32.size() != DEPTH);
        e32 = ref_decode(ins, pc, 1'b0);
        e64 = ref_decode(ins, pc, 1'b1);
        @(posedge clock);
        #1;
        if (fl) begin
            q32.delete(); q64.delete();
        end else if (acc) begin
            q32.push_back(e32); q64.push_back(e64);
        end
    endtask

    task automatic idle(bit rdy);
        drive(1'b0, 32'h0000_0013, 64'h0, 1'b0, rdy);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] ops [9] = '{5'b01101, 5'b00101, 5'b00100, 5'b01100, 5'b00000,
                                 5'b01000, 5'b11011, 5'b11001, 5'b11000};
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) r[6:2] = ops[k];
        if ($urandom_range(0, 9) != 0) r[1:0] = 2'b11;
        case ($urandom_range(0, 5))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:26] = 6'h10;
            default: ;
        endcase
        return r;
    endfunction

    // Monitor: presented head vs expected queue front; pops on an accepted handshake
    always @(negedge clock) begin
        if (mon_en && nReset) begin
            chk("count32", 64'(if32.count), 64'(q32.size()));
            chk("count64", 64'(if64.count), 64'(q64.size()));
            chk("in_ready32", 64'(if32.in_ready), 64'(q32.size() != DEPTH));
            chk("in_ready64", 64'(if64.in_ready), 64'(q64.size() != DEPTH));
            chk("out_valid32", 64'(if32.out_valid), 64'(q32.size() != 0));
            chk("out_valid64", 64'(if64.out_valid), 64'(q64.size() != 0));
            if (q32.size() != 0) begin
                chk("pc32", 64'(if32.out_pc), q32[0].pc);
                chk("imm32", 64'(if32.out_imm), q32[0].imm);
                chk("regs32", {49'b0, if32.out_rd, if32.out_rs1, if32.out_rs2},
                              {49'b0, q32[0].rd, q32[0].rs1, q32[0].rs2});
                chk("ctl32", {44'b0, if32.out_funct3, if32.out_alu_code, if32.out_branch_type,
                              if32.out_ctrl, if32.out_illegal},
                             {44'b0, q32[0].f3, q32[0].alu, q32[0].br, q32[0].ctrl, q32[0].ill});
            end else begin
                chk("idle_data32", 64'(if32.out_imm) | 64'(if32.out_pc) | 64'(if32.out_ctrl), 64'h0);
            end
            if (q64.size() != 0) begin
                chk("pc64", if64.out_pc, q64[0].pc);
                chk("imm64", if64.out_imm, q64[0].imm);
                chk("ctl64", {44'b0, if64.out_funct3, if64.out_alu_code, if64.out_branch_type,
                              if64.out_ctrl, if64.out_illegal},
                             {44'b0, q64[0].f3, q64[0].alu, q64[0].br, q64[0].ctrl, q64[0].ill});
            end else begin
                chk("idle_data64", if64.out_imm | if64.out_pc | 64'(if64.out_ctrl), 64'h0);
            end
            if (out_ready && !flush) begin
                if (q32.size() != 0) void'(q32.pop_front());
                if (q64.size() != 0) void'(q64.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        in_valid = 1'b1; in_instr = 32'hFFF0_0093;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(if32.out_valid), 64'h0);
        chk("rst_in_ready", 64'(if32.in_ready), 64'h1);
        chk("rst_count", 64'(if32.count), 64'h0);
        chk("rst_count64", 64'(if64.count), 64'h0);
        in_valid = 1'b0;
        nReset = 1'b1;
        mon_en = 1'b1;
        @(posedge clock); #1;
        idle(1'b1); idle(1'b1);
        chk("post_rst_count", 64'(if32.count), 64'h0);

        // addi x1,x0,-1
        drive(1'b1, 32'hFFF0_0093, 64'h100, 1'b0, 1'b1);
        chk("addi_valid", 64'(if32.out_valid), 64'h1);
        chk("addi_imm", 64'(if32.out_imm), 64'hFFFF_FFFF);
        chk("addi_rd", 64'(if32.out_rd), 64'd1);
        chk("addi_ctrl", 64'(if32.out_ctrl), 64'h04E);
        chk("addi_pc", 64'(if32.out_pc), 64'h100);
        idle(1'b1);
        chk("addi_count0", 64'(if32.count), 64'h0);

        // beq x1,x2,-4
        drive(1'b1, 32'hFE20_8EE3, 64'h200, 1'b0, 1'b1);
        chk("beq_imm", 64'(if32.out_imm), 64'hFFFF_FFFC);
        chk("beq_regs", {54'b0, if32.out_rs1, if32.out_rs2}, {54'b0, 5'd1, 5'd2});
        chk("beq_alu_br", {58'b0, if32.out_alu_code, if32.out_branch_type}, {58'b0, 4'b1000, 2'd3});
        chk("beq_ctrl", 64'(if32.out_ctrl), 64'h000);
        idle(1'b1);

        // Fill to full, hold C, single pop reopens next cycle
        drive(1'b1, 32'h0010_0113, 64'h300, 1'b0, 1'b0);
        drive(1'b1, 32'h0020_0193, 64'h304, 1'b0, 1'b0);
        chk("full_count", 64'(if32.count), 64'd2);
        chk("full_in_ready", 64'(if32.in_ready), 64'h0);
        drive(1'b1, 32'h0030_0213, 64'h308, 1'b0, 1'b0);
        chk("held_count", 64'(if32.count), 64'd2);
        drive(1'b1, 32'h0030_0213, 64'h308, 1'b0, 1'b1);
        chk("reopen_in_ready", 64'(if32.in_ready), 64'h1);
        drive(1'b1, 32'h0030_0213, 64'h308, 1'b0, 1'b0);
        repeat (3) idle(1'b1);

        // Flush with two buffered and a concurrent offer
        drive(1'b1, 32'h0040_0293, 64'h400, 1'b0, 1'b0);
        drive(1'b1, 32'h0050_0313, 64'h404, 1'b0, 1'b0);
        drive(1'b1, 32'h0060_0393, 64'h408, 1'b1, 1'b0);
        chk("flush_count", 64'(if32.count), 64'h0);
        chk("flush_valid", 64'(if32.out_valid), 64'h0);
        chk("flush_in_ready", 64'(if32.in_ready), 64'h1);
        repeat (2) idle(1'b1);

        // All-zero word is illegal; lui sign-extends on RV64
        drive(1'b1, 32'h0000_0000, 64'h500, 1'b0, 1'b1);
        chk("zero_illegal", 64'(if32.out_illegal), 64'h1);
        chk("zero_alu", 64'(if32.out_alu_code), 64'hF);
        chk("zero_ctrl", 64'(if32.out_ctrl), 64'h0);
        drive(1'b1, 32'h8000_00B7, 64'h600, 1'b0, 1'b1);
        chk("lui64_imm", if64.out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui64_ctrl", 64'(if64.out_ctrl), 64'h040);
        chk("lui32_imm", 64'(if32.out_imm), 64'h8000_0000);
        idle(1'b1);

        // Randomized traffic with an asynchronous reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                mon_en = 1'b0;
                in_valid = 1'b0; flush = 1'b0;
                #2 nReset = 1'b0;
                #1;
                chk("async_rst_count", 64'(if32.count), 64'h0);
                chk("async_rst_valid", 64'(if64.out_valid), 64'h0);
                chk("async_rst_in_ready", 64'(if32.in_ready), 64'h1);
                q32.delete(); q64.delete();
                @(posedge clock); #1;
                nReset = 1'b1;
                mon_en = 1'b1;
            end
            drive($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom},
                  $urandom_range(0, 32) == 0, $urandom_range(0, 2) != 0);
        end
        repeat (4) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
